// File: rtl/uart_fifo_rx_tx_pkg.sv
// Shared types and helpers for uart_fifo_rx_tx: FSM state enums, parity modes, clog2.
// PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif

  // Width needed to hold values 0..v-1, never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_fifo_rx_tx_if.sv
// Valid/ready word interface between on-chip logic (master) and the UART (slave).
interface uart_fifo_rx_tx_if #(parameter int unsigned DATA_BITS = 8);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;

  modport master (output tx_valid, tx_data, rx_ready,
                  input  tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun);
  modport slave  (input  tx_valid, tx_data, rx_ready,
                  output tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun);
endinterface

// File: rtl/uart_fifo_rx_tx_tick_gen.sv
// Clock divider giving a one-cycle tick every DIV cycles, plus a flag one cycle ahead of it.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick,
  output logic o_pre
);
  localparam int unsigned  CW   = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_restart) r_cnt <= '0;
    else if (r_cnt == LAST)    r_cnt <= '0;
    else                       r_cnt <= r_cnt + 1'b1;
  end

  always_comb begin
    o_tick = (r_cnt == LAST);
    o_pre  = (DIV == 1) ? 1'b1 : (r_cnt == PRE);
  end
endmodule

// File: rtl/uart_fifo_rx_tx.sv
// Full-duplex oversampling UART with valid/ready handshakes and a one-deep RX holding register.
// Define UART_PARITY_EN to build parity generation/check honouring the PARITY parameter.
module uart_fifo_rx_tx
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rx,
  output logic             o_tx,
  uart_fifo_rx_tx_if.slave bus
);
  localparam int unsigned CLK_DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned CLK_DIV     = (CLK_DIV_RAW < 1) ? 1 : CLK_DIV_RAW;
`ifdef UART_PARITY_EN
  localparam int unsigned PAR_MODE = PARITY;
`else
  localparam int unsigned PAR_MODE = PAR_NONE;
`endif
  localparam logic            PAR_INV  = (PAR_MODE == PAR_ODD);
  localparam int unsigned     TW       = clog2(OVERSAMPLE);
  localparam int unsigned     BW       = clog2(DATA_BITS);
  localparam logic [TW-1:0]   T_S0     = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0]   T_S1     = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0]   T_S2     = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0]   T_PRE    = TW'(OVERSAMPLE - 2);
  localparam logic [TW-1:0]   T_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);

  // ---------------- receiver ----------------
  rx_state_t            r_rx_state, w_rx_next;
  logic [1:0]           r_sync;
  logic                 r_rx_prev;
  logic [TW-1:0]        r_rx_tcnt;
  logic [BW-1:0]        r_rx_bitcnt;
  logic [DATA_BITS-1:0] r_rx_shift, r_rx_data;
  logic [1:0]           r_vote;
  logic                 r_rx_valid, r_ferr, r_perr, r_ovr;
  logic                 w_rxs, w_fall, w_bit, w_rx_tick, w_rx_pre_unused, w_rx_mid, w_rx_end;
  logic                 w_rx_restart, w_good, w_bad, w_load, w_ovr, w_perr;
`ifdef UART_PARITY_EN
  logic                 r_rx_par;
`endif

  assign w_rxs    = r_sync[1];
  assign w_fall   = r_rx_prev & ~w_rxs;
  assign w_bit    = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rxs) | (r_vote[1] & w_rxs);
  assign w_rx_mid = w_rx_tick && (r_rx_tcnt == T_S2);
  assign w_rx_end = w_rx_tick && (r_rx_tcnt == T_LAST);

  uart_tick_gen #(.DIV(CLK_DIV)) u_rx_tick (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_restart(w_rx_restart),
    .o_tick(w_rx_tick), .o_pre(w_rx_pre_unused)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_rx_state <= RX_IDLE;
    else          r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_fall) w_rx_next = RX_START;
      RX_START: if (w_rx_mid && w_bit) w_rx_next = RX_IDLE;
                else if (w_rx_end)     w_rx_next = RX_DATA;
`ifdef UART_PARITY_EN
      RX_DATA:  if (w_rx_end && r_rx_bitcnt == LAST_BIT)
                  w_rx_next = (PAR_MODE != PAR_NONE) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_end) w_rx_next = RX_STOP;
`else
      RX_DATA:  if (w_rx_end && r_rx_bitcnt == LAST_BIT) w_rx_next = RX_STOP;
`endif
      // Leave at mid stop bit so a start edge straight after it is not missed.
      RX_STOP:  if (w_rx_mid) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_restart = (r_rx_state == RX_IDLE) && w_fall;
    w_good       = (r_rx_state == RX_STOP) && w_rx_mid && w_bit;
    w_bad        = (r_rx_state == RX_STOP) && w_rx_mid && !w_bit;
    w_load       = w_good && (!r_rx_valid || bus.rx_ready);
    w_ovr        = w_good && r_rx_valid && !bus.rx_ready;
`ifdef UART_PARITY_EN
    w_perr       = w_good && (PAR_MODE != PAR_NONE) && (r_rx_par != (^r_rx_shift ^ PAR_INV));
`else
    w_perr       = 1'b0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync      <= '1;
      r_rx_prev   <= 1'b1;
      r_rx_tcnt   <= '0;
      r_rx_bitcnt <= '0;
      r_rx_shift  <= '0;
      r_vote      <= '1;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_ferr      <= 1'b0;
      r_perr      <= 1'b0;
      r_ovr       <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par    <= 1'b0;
`endif
    end else begin
      r_sync    <= {r_sync[0], i_rx};
      r_rx_prev <= w_rxs;
      if (w_rx_restart) begin
        r_rx_tcnt   <= '0;
        r_rx_bitcnt <= '0;
      end else if (r_rx_state != RX_IDLE && w_rx_tick) begin
        r_rx_tcnt <= (r_rx_tcnt == T_LAST) ? '0 : r_rx_tcnt + 1'b1;
        if (r_rx_state == RX_DATA && r_rx_tcnt == T_LAST) r_rx_bitcnt <= r_rx_bitcnt + 1'b1;
      end
      if (w_rx_tick && r_rx_tcnt == T_S0) r_vote[0] <= w_rxs;
      if (w_rx_tick && r_rx_tcnt == T_S1) r_vote[1] <= w_rxs;
      if (r_rx_state == RX_DATA && w_rx_mid) r_rx_shift <= {w_bit, r_rx_shift[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
      if (r_rx_state == RX_PARITY && w_rx_mid) r_rx_par <= w_bit;
`endif
      if (w_load) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      r_ferr <= w_bad;
      r_perr <= w_perr;
      r_ovr  <= w_ovr;
    end
  end

  assign bus.rx_valid      = r_rx_valid;
  assign bus.rx_data       = r_rx_data;
  assign bus.rx_frame_err  = r_ferr;
  assign bus.rx_parity_err = r_perr;
  assign bus.rx_overrun    = r_ovr;

  // ---------------- transmitter ----------------
  tx_state_t            r_tx_state, w_tx_next;
  logic [TW-1:0]        r_tx_tcnt;
  logic [BW-1:0]        r_tx_bitcnt;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_stopcnt;
  logic                 w_tx_tick, w_tx_pre, w_tx_hs, w_tx_end, w_tx_stop_done;
`ifdef UART_PARITY_EN
  logic                 r_tx_par;
`endif

  uart_tick_gen #(.DIV(CLK_DIV)) u_tx_tick (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_restart(1'b0),
    .o_tick(w_tx_tick), .o_pre(w_tx_pre)
  );

  assign w_tx_hs  = bus.tx_valid && (r_tx_state == TX_IDLE);
  assign w_tx_end = w_tx_tick && (r_tx_tcnt == T_LAST);
  // The last stop bit exits one cycle before its final tick; the IDLE cycle completes
  // it, so a handshake there starts the next frame with no added idle time.
  assign w_tx_stop_done = (r_tx_stopcnt == 1'(STOP_BITS - 1)) && w_tx_pre &&
                          (w_tx_tick ? (r_tx_tcnt == T_PRE) : (r_tx_tcnt == T_LAST));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_tx_state <= TX_IDLE;
    else          r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (w_tx_hs) w_tx_next = TX_START;
      TX_START: if (w_tx_end) w_tx_next = TX_DATA;
`ifdef UART_PARITY_EN
      TX_DATA:  if (w_tx_end && r_tx_bitcnt == LAST_BIT)
                  w_tx_next = (PAR_MODE != PAR_NONE) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (w_tx_end) w_tx_next = TX_STOP;
`else
      TX_DATA:  if (w_tx_end && r_tx_bitcnt == LAST_BIT) w_tx_next = TX_STOP;
`endif
      TX_STOP:  if (w_tx_stop_done) w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    o_tx         = 1'b1;
    bus.tx_ready = 1'b0;
    case (r_tx_state)
      TX_IDLE:   bus.tx_ready = 1'b1;
      TX_START:  o_tx = 1'b0;
      TX_DATA:   o_tx = r_tx_shift[0];
`ifdef UART_PARITY_EN
      TX_PARITY: o_tx = r_tx_par;
`endif
      default:   o_tx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx_tcnt    <= '0;
      r_tx_bitcnt  <= '0;
      r_tx_shift   <= '0;
      r_tx_stopcnt <= 1'b0;
`ifdef UART_PARITY_EN
      r_tx_par     <= 1'b0;
`endif
    end else if (w_tx_hs) begin
      r_tx_tcnt    <= '0;
      r_tx_bitcnt  <= '0;
      r_tx_shift   <= bus.tx_data;
      r_tx_stopcnt <= 1'b0;
`ifdef UART_PARITY_EN
      r_tx_par     <= ^bus.tx_data ^ PAR_INV;
`endif
    end else if (r_tx_state != TX_IDLE && w_tx_tick) begin
      r_tx_tcnt <= (r_tx_tcnt == T_LAST) ? '0 : r_tx_tcnt + 1'b1;
      if (r_tx_state == TX_DATA && r_tx_tcnt == T_LAST) begin
        r_tx_shift  <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
        r_tx_bitcnt <= r_tx_bitcnt + 1'b1;
      end
      if (r_tx_state == TX_STOP && r_tx_tcnt == T_LAST) r_tx_stopcnt <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_fifo_rx_tx.sv
// Directed self-checking bench for uart_fifo_rx_tx at CLK_DIV = 1 (16 cycles per bit).
module tb_uart_fifo_rx_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r_loop = 1'b0;
  logic r_rx_drv = 1'b1;
  logic r_prx = 1'b1;
  logic w_tx, w_ptx, w_rx;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned n_ferr = 0, n_perr = 0, n_ovr = 0, n_pperr = 0;

  always #5 clk = ~clk;

  uart_fifo_rx_tx_if #(.DATA_BITS(8)) u_if ();
  uart_fifo_rx_tx_if #(.DATA_BITS(7)) u_pif ();

  assign w_rx = r_loop ? w_tx : r_rx_drv;

  uart_fifo_rx_tx #(
    .SYS_CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut (.i_clk(clk), .i_rst_n(rst_n), .i_rx(w_rx), .o_tx(w_tx), .bus(u_if));

  uart_fifo_rx_tx #(
    .SYS_CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
  ) p_dut (.i_clk(clk), .i_rst_n(rst_n), .i_rx(r_prx), .o_tx(w_ptx), .bus(u_pif));

  always @(posedge clk) begin
    if (u_if.rx_frame_err)   n_ferr  <= n_ferr + 1;
    if (u_if.rx_parity_err)  n_perr  <= n_perr + 1;
    if (u_if.rx_overrun)     n_ovr   <= n_ovr + 1;
    if (u_pif.rx_parity_err) n_pperr <= n_pperr + 1;
  end

  // Handshake one word on the 8-bit DUT; returns 1 ns after the accepting edge.
  task automatic tx_handshake(input logic [7:0] d);
    @(negedge clk);
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = d;
    for (int i = 0; i < 400; i++) begin
      if (u_if.tx_ready) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1 u_if.tx_valid = 1'b0;
  endtask

  // Drive n bits (index 0 first) on the chosen rx line, 16 cycles each, then idle high.
  task automatic send_rx(input logic sel, input logic [11:0] bits, input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (sel) r_prx = bits[i]; else r_rx_drv = bits[i];
      repeat (16) @(negedge clk);
    end
    if (sel) r_prx = 1'b1; else r_rx_drv = 1'b1;
  endtask

  task automatic rx_read;
    @(negedge clk);
    u_if.rx_ready = 1'b1;
    @(negedge clk);
    u_if.rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks += 6;
    if (w_tx !== 1'b1)               begin errors++; $display("FAIL reset_tx got=%b exp=1", w_tx); end
    if (u_if.tx_ready !== 1'b1)      begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", u_if.tx_ready); end
    if (u_if.rx_valid !== 1'b0)      begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", u_if.rx_valid); end
    if (u_if.rx_data !== 8'h00)      begin errors++; $display("FAIL reset_rx_data got=%h exp=00", u_if.rx_data); end
    if ({u_if.rx_frame_err, u_if.rx_parity_err, u_if.rx_overrun} !== 3'b000)
      begin errors++; $display("FAIL reset_err_pulses got=%b exp=000",
                               {u_if.rx_frame_err, u_if.rx_parity_err, u_if.rx_overrun}); end
    if (u_pif.rx_valid !== 1'b0)     begin errors++; $display("FAIL reset_p_rx_valid got=%b exp=0", u_pif.rx_valid); end
  endtask

  task automatic test_8n1_loopback;
    logic [9:0] exp_bits;
    int unsigned e0, p0, o0;
    logic ok;
    exp_bits = 10'b11_0100_1010;  // index 0 = start: 0,1,0,1,0,0,1,0,1,1
    e0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    r_loop = 1'b1;
    tx_handshake(8'hA5);
    repeat (8) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) repeat (16) @(posedge clk);
      #1;
      checks++;
      if (w_tx !== exp_bits[k]) begin errors++; $display("FAIL a5_tx_bit%0d got=%b exp=%b", k, w_tx, exp_bits[k]); end
    end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (u_if.rx_valid) begin ok = 1'b1; break; end
    end
    checks += 3;
    if (ok !== 1'b1)            begin errors++; $display("FAIL a5_rx_valid_timeout got=%b exp=1", ok); end
    if (u_if.rx_data !== 8'hA5) begin errors++; $display("FAIL a5_rx_data got=%h exp=a5", u_if.rx_data); end
    if ((n_ferr - e0) + (n_perr - p0) + (n_ovr - o0) != 0)
      begin errors++; $display("FAIL a5_no_errors got=%0d exp=0", (n_ferr - e0) + (n_perr - p0) + (n_ovr - o0)); end
    rx_read;
    #1;
    checks++;
    if (u_if.rx_valid !== 1'b0) begin errors++; $display("FAIL a5_read_clears got=%b exp=0", u_if.rx_valid); end
    r_loop = 1'b0;
  endtask

  task automatic test_frame_error;
    int unsigned e0;
    e0 = n_ferr;
    send_rx(1'b0, {2'b00, 1'b0, 8'h55, 1'b0}, 10);
    repeat (20) @(posedge clk); #1;
    checks += 2;
    if (n_ferr - e0 != 1)       begin errors++; $display("FAIL ferr_pulse_count got=%0d exp=1", n_ferr - e0); end
    if (u_if.rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_rx_valid got=%b exp=0", u_if.rx_valid); end
  endtask

  task automatic test_overrun;
    int unsigned o0;
    o0 = n_ovr;
    send_rx(1'b0, {2'b00, 1'b1, 8'h11, 1'b0}, 10);
    send_rx(1'b0, {2'b00, 1'b1, 8'h22, 1'b0}, 10);
    repeat (20) @(posedge clk); #1;
    checks += 3;
    if (u_if.rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_rx_valid got=%b exp=1", u_if.rx_valid); end
    if (u_if.rx_data !== 8'h11) begin errors++; $display("FAIL ovr_rx_data got=%h exp=11", u_if.rx_data); end
    if (n_ovr - o0 != 1)        begin errors++; $display("FAIL ovr_pulse_count got=%0d exp=1", n_ovr - o0); end
    rx_read;
    #1;
    checks++;
    if (u_if.rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_read_clears got=%b exp=0", u_if.rx_valid); end
  endtask

  task automatic test_glitch;
    int unsigned e0, p0, o0;
    e0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    @(negedge clk);
    r_rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    r_rx_drv = 1'b1;
    repeat (40) @(posedge clk); #1;
    checks += 2;
    if (u_if.rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_rx_valid got=%b exp=0", u_if.rx_valid); end
    if ((n_ferr - e0) + (n_perr - p0) + (n_ovr - o0) != 0)
      begin errors++; $display("FAIL glitch_errors got=%0d exp=0", (n_ferr - e0) + (n_perr - p0) + (n_ovr - o0)); end
    // receiver must be idle again and catch a real frame
    send_rx(1'b0, {2'b00, 1'b1, 8'h5A, 1'b0}, 10);
    #1;
    checks += 2;
    if (u_if.rx_valid !== 1'b1) begin errors++; $display("FAIL glitch_next_valid got=%b exp=1", u_if.rx_valid); end
    if (u_if.rx_data !== 8'h5A) begin errors++; $display("FAIL glitch_next_data got=%h exp=5a", u_if.rx_data); end
    rx_read;
  endtask

  task automatic test_reset_mid_tx;
    logic [9:0] exp_bits;
    logic ok;
    exp_bits = 10'b10_0111_1000;  // 0x3C framed: 0,0,0,1,1,1,1,0,0,1
    tx_handshake(8'h3C);
    repeat (72) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks += 2;
    if (w_tx !== 1'b1)          begin errors++; $display("FAIL rst_mid_tx got=%b exp=1", w_tx); end
    if (u_if.tx_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_tx_ready got=%b exp=1", u_if.tx_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    r_loop = 1'b1;
    repeat (4) @(negedge clk);
    tx_handshake(8'h3C);
    repeat (8) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) repeat (16) @(posedge clk);
      #1;
      checks++;
      if (w_tx !== exp_bits[k]) begin errors++; $display("FAIL 3c_tx_bit%0d got=%b exp=%b", k, w_tx, exp_bits[k]); end
    end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (u_if.rx_valid) begin ok = 1'b1; break; end
    end
    checks += 2;
    if (ok !== 1'b1)            begin errors++; $display("FAIL 3c_rx_valid_timeout got=%b exp=1", ok); end
    if (u_if.rx_data !== 8'h3C) begin errors++; $display("FAIL 3c_rx_data got=%h exp=3c", u_if.rx_data); end
    rx_read;
    r_loop = 1'b0;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    logic [9:0] exp_bits;
    int unsigned p0;
    exp_bits = 10'b10_1000_0010;  // 0x41, 7E1: 0,1,0,0,0,0,0,1,0,1
    @(negedge clk);
    u_pif.tx_valid = 1'b1;
    u_pif.tx_data  = 7'h41;
    @(posedge clk);
    #1 u_pif.tx_valid = 1'b0;
    repeat (8) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) repeat (16) @(posedge clk);
      #1;
      checks++;
      if (w_ptx !== exp_bits[k]) begin errors++; $display("FAIL par_tx_bit%0d got=%b exp=%b", k, w_ptx, exp_bits[k]); end
    end
    p0 = n_pperr;
    send_rx(1'b1, {2'b00, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
    #1;
    checks += 3;
    if (n_pperr - p0 != 1)       begin errors++; $display("FAIL par_err_count got=%0d exp=1", n_pperr - p0); end
    if (u_pif.rx_valid !== 1'b1) begin errors++; $display("FAIL par_rx_valid got=%b exp=1", u_pif.rx_valid); end
    if (u_pif.rx_data !== 7'h41) begin errors++; $display("FAIL par_rx_data got=%h exp=41", u_pif.rx_data); end
  endtask
`endif

  initial begin
    u_if.tx_valid  = 1'b0;
    u_if.tx_data   = '0;
    u_if.rx_ready  = 1'b0;
    u_pif.tx_valid = 1'b0;
    u_pif.tx_data  = '0;
    u_pif.rx_ready = 1'b0;
    test_reset;
    test_8n1_loopback;
    test_frame_error;
    test_overrun;
    test_glitch;
    test_reset_mid_tx;
`ifdef UART_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_fifo_rx_tx.md
# uart_fifo_rx_tx

Parametrised full-duplex UART with configurable data width, parity mode, stop-bit count and oversampling ratio. The receiver uses a majority-voted oversampled front end, and both directions use valid/ready handshakes. A one-deep receive holding register reports overrun. It sits between on-chip logic and the board serial pins and supersedes the fixed 8N2 UART for new designs.

## Interface
- SYS_CLK_FREQ, 100000000, clk frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s
- OVERSAMPLE, 16, sample ticks per bit; even, 8..16
- DATA_BITS, 8, payload bits per frame, 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- clk  in  1  master clock
- rst_n  in  1  synchronous reset, active-low
- rx  in  1  serial input, asynchronous, idles high
- tx  out  1  serial output, idles high
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  transmitter can accept a word
- tx_data  in  DATA_BITS  word to send, LSB first
- rx_valid  out  1  rx_data holds an unread word
- rx_ready  in  1  consumer accepts rx_data
- rx_data  out  DATA_BITS  received word
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
- rx_parity_err  out  1  one-cycle pulse: parity mismatch
- rx_overrun  out  1  one-cycle pulse: word dropped because the holding register was full

## Operation
- Tick generator: CLK_DIV = SYS_CLK_FREQ/(BAUD_RATE*OVERSAMPLE), minimum 1.
  - Separate free-running tick counters for RX and TX.
  - The RX counter reloads on start-bit detection.
- RX input passes through a 2-FF synchroniser before any use.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge on synchronised rx enters START and clears the tick count.
  - Each bit is sampled at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority.
  - START: a voted 1 is a glitch. Return to IDLE with no error.
  - DATA: shift in DATA_BITS bits, LSB first.
  - PARITY: entered only if PARITY != 0.
  - STOP: only the first stop bit is checked. On a voted 0, pulse rx_frame_err and discard the word.
  - After STOP, return to IDLE at the mid-point of the stop bit so the next start edge can be caught.
- RX commit, on a good stop bit:
  - If rx_valid = 0: load rx_data and set rx_valid.
  - If rx_valid = 1 and rx_ready = 0: pulse rx_overrun and keep the old data.
  - rx_parity_err pulses in the same cycle as the commit. The word is still delivered.
  - rx_valid clears on the cycle rx_valid & rx_ready.
  - Simultaneous commit and read: the new word loads and rx_valid stays 1.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - tx_ready = 1 only in IDLE.
  - The tx_valid & tx_ready handshake latches tx_data and drives the start bit on the next cycle.
  - Each bit lasts OVERSAMPLE ticks.
  - The STOP state lasts STOP_BITS bit periods, then returns to IDLE.
  - tx_valid held high sends frames back-to-back, with no extra idle between them.
- Parity is the XOR of the data bits, inverted for odd parity.

## Timing
- Reset values:
  - tx = 1, tx_ready = 1.
  - rx_valid = 0, rx_data = 0, all error pulses = 0.
  - Both FSMs in IDLE, tick counters at 0.
- Reset asserted mid-frame aborts it: tx returns to 1 on the next cycle.
- RX latency: the commit cycle falls within 1 tick of the stop-bit mid-point, plus 2 cycles of synchroniser delay.
- TX: the start-bit edge on tx is 1 cycle after the handshake.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × OVERSAMPLE × CLK_DIV cycles.
- Error pulses are exactly 1 cycle wide.

## Configuration
- UART_PARITY_EN defined: the PARITY parameter is honoured and the parity generation and check logic is built.
- UART_PARITY_EN undefined:
  - The PARITY parameter is ignored and treated as 0.
  - No PARITY states exist in either FSM.
  - rx_parity_err is tied to 0.

## Structure
- Package uart_pkg:
  - RX and TX state enums.
  - Parity-mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - A clog2 helper function.
- Sub-module uart_tick_gen: a parametrised divider producing a one-cycle tick enable, with a synchronous restart input.
  - Instantiated twice, once for RX and once for TX.

## Test plan
Bench configuration unless noted: SYS_CLK_FREQ = 16000000, BAUD_RATE = 1000000, OVERSAMPLE = 16, so CLK_DIV = 1 and one bit = 16 cycles.
- 8N1: send 0xA5 → tx shows 0,1,0,1,0,0,1,0,1,1 in 16-cycle bits. Loopback delivers rx_data = 0xA5 with rx_valid set, no errors.
- PARITY = 2, DATA_BITS = 7, UART_PARITY_EN defined: send 0x41 → parity bit 0. A bench frame with a flipped parity bit → rx_parity_err pulses 1 cycle and rx_data = 0x41.
- Stop bit driven low → rx_frame_err pulses, rx_valid stays 0.
- Two frames, 0x11 then 0x22, with rx_ready = 0 → rx_data = 0x11 and rx_overrun pulses once.
- A 5-cycle low glitch on idle rx → no rx_valid, no errors, FSM back in IDLE.
- rst_n low mid-TX (bit 3) → tx = 1 and tx_ready = 1 the next cycle. The next 0x3C frame is sent correctly.
